// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the two-phase toggle req/ack CDC handshake (source and destination ends).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cdc_hs_pkg;

    localparam logic [1:0] HS_ENC_INIT     = 2'd0;
    localparam logic [1:0] HS_ENC_IDLE     = 2'd1;
    localparam logic [1:0] HS_ENC_WAIT_ACK = 2'd2;

    localparam int SYNC_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        ST_INIT     = HS_ENC_INIT,
        ST_IDLE     = HS_ENC_IDLE,
        ST_WAIT_ACK = HS_ENC_WAIT_ACK
    } hs_state_e;

endpackage

// File: rtl/dff_sync.sv
// Multi-flop single-bit synchronizer with asynchronous active-low reset to RST_VAL.
// Latency: DEPTH clk edges from d to q.
// Backpressure: none; free-running.
module dff_sync #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/cdc_hs_src.sv
// Source end of a two-phase toggle req/ack CDC: captures a word, toggles cdc_req, waits for ack toggle.
// Latency: with loopback ack, src_ready returns SYNC_DEPTH+1 edges after accept (1 word / SYNC_DEPTH+2 cycles).
// Backpressure: src_ready held low until the returned ack parity matches cdc_req; no timeout.
module cdc_hs_src
    import cdc_hs_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int SYNC_DEPTH = SYNC_DEPTH_DEF
) (
    input  logic              src_clk,
    input  logic              src_rst_n,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              src_err,
    output logic              cdc_req,
    output logic [DATA_W-1:0] cdc_data,
    input  logic              cdc_ack
);

    hs_state_e         state_q, state_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ack_s;

    dff_sync #(
        .DEPTH   (SYNC_DEPTH),
        .RST_VAL (1'b0)
    ) u_ack_sync (
        .clk   (src_clk),
        .rst_n (src_rst_n),
        .d     (cdc_ack),
        .q     (ack_s)
    );

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        err_d   = err_q;
        req_d   = req_q;
        data_d  = data_q;
        case (state_q)
            ST_INIT: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // Parity mismatch while nothing is outstanding means the far side toggled on its own.
                if (ack_s != req_q) begin
                    err_d = 1'b1;
                end
                if (src_valid && ready_q) begin
                    data_d  = src_data;
                    req_d   = ~req_q;
                    ready_d = 1'b0;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_s == req_q) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            state_q <= ST_INIT;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    assign src_ready = ready_q;
    assign src_err   = err_q;
    assign cdc_req   = req_q;
    assign cdc_data  = data_q;

endmodule

// File: tb/tb_cdc_hs_src.sv
// Bench for cdc_hs_src: transaction-level model with an ack delay line, loopback or frozen ack.
module tb_cdc_hs_src;

    localparam int DW = 8;
    localparam int SD = 2;

    logic          src_clk   = 1'b0;
    logic          src_rst_n = 1'b0;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data  = '0;
    logic          src_ready;
    logic          src_err;
    logic          cdc_req;
    logic [DW-1:0] cdc_data;
    logic          cdc_ack;

    // Ack either loops straight back from cdc_req or is frozen at frz_val.
    logic frz     = 1'b0;
    logic frz_val = 1'b0;
    assign cdc_ack = frz ? frz_val : cdc_req;

    cdc_hs_src #(.DATA_W(DW), .SYNC_DEPTH(SD)) dut (
        .src_clk   (src_clk),
        .src_rst_n (src_rst_n),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .src_err   (src_err),
        .cdc_req   (cdc_req),
        .cdc_data  (cdc_data),
        .cdc_ack   (cdc_ack)
    );

    always #5 src_clk = ~src_clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic          m_ready, m_req, m_err, m_init;
    logic [DW-1:0] m_data;
    logic [SD-1:0] ack_dly;
    logic [DW-1:0] exp_q[$];
    logic          prev_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ready  = 1'b0;
        m_req    = 1'b0;
        m_err    = 1'b0;
        m_init   = 1'b0;
        m_data   = '0;
        ack_dly  = '0;
        prev_req = 1'b0;
    endtask

    // Predict the effect of the coming posedge from the inputs currently driven.
    task automatic model_edge();
        logic seen;
        logic ack_now;
        if (!src_rst_n) return;
        ack_now = frz ? frz_val : cdc_req;
        seen    = ack_dly[SD-1];
        ack_dly = {ack_dly[SD-2:0], ack_now};
        if (m_init) begin
            m_init  = 1'b0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            if (seen != m_req) m_err = 1'b1;
            if (src_valid) begin
                m_data  = src_data;
                m_req   = ~m_req;
                m_ready = 1'b0;
                exp_q.push_back(src_data);
            end
        end else if (seen == m_req) begin
            m_ready = 1'b1;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(negedge src_clk);
        chk("ready", 32'(src_ready), 32'(m_ready));
        chk("req",   32'(cdc_req),   32'(m_req));
        chk("data",  32'(cdc_data),  32'(m_data));
        chk("err",   32'(src_err),   32'(m_err));
        if (src_rst_n && (cdc_req != prev_req)) begin
            prev_req = cdc_req;
            if (exp_q.size() == 0) chk("sb_extra", 32'(cdc_data), 32'hFFFF_FFFF);
            else                   chk("sb_word", 32'(cdc_data), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!src_ready && n < 20) begin
            cycle();
            n++;
        end
        if (!src_ready) chk("idle_timeout", 32'(src_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w[3];
        int acc_t[3];
        int idx;
        int n;

        model_reset();
        w = '{8'h01, 8'h02, 8'h03};
        acc_t = '{0, 0, 0};

        // Reset held 5 cycles, then released between edges
        repeat (5) cycle();
        src_rst_n = 1'b1;
        m_init    = 1'b1;
        #1 chk("rst_rel_ready", 32'(src_ready), 32'd0);
        cycle();
        chk("init_ready", 32'(src_ready), 32'd1);

        // Single transfer 0xA5 with loopback
        src_valid = 1'b1;
        src_data  = 8'hA5;
        cycle();
        src_valid = 1'b0;
        chk("a5_data", 32'(cdc_data), 32'hA5);
        chk("a5_req",  32'(cdc_req),  32'd1);
        n = 1;
        while (!src_ready && n < 10) begin
            cycle();
            if (!src_ready) n++;
        end
        chk("a5_low_cycles", 32'(n), 32'(SD + 1));

        // Back-to-back words with valid held high
        idx = 0;
        for (int c = 0; c < 40 && idx < 3; c++) begin
            src_valid = 1'b1;
            src_data  = w[idx];
            if (src_ready) begin
                acc_t[idx] = c;
                idx++;
            end
            cycle();
        end
        src_valid = 1'b0;
        chk("b2b_count", 32'(idx), 32'd3);
        chk("b2b_gap1", 32'(acc_t[1] - acc_t[0]), 32'(SD + 2));
        chk("b2b_gap2", 32'(acc_t[2] - acc_t[1]), 32'(SD + 2));
        wait_ready();

        // Randomized traffic with random ack stalls
        for (int c = 0; c < 400; c++) begin
            src_valid = 1'($urandom % 2);
            src_data  = 8'($urandom);
            if (frz) begin
                if ($urandom % 4 == 0) frz = 1'b0;
            end else if ($urandom % 8 == 0) begin
                frz_val = cdc_req;
                frz     = 1'b1;
            end
            cycle();
        end
        src_valid = 1'b0;
        frz       = 1'b0;
        wait_ready();

        // Ack stalled 20 cycles while src_data churns
        src_valid = 1'b1;
        src_data  = 8'h3C;
        frz_val   = cdc_req;
        frz       = 1'b1;
        cycle();
        for (int c = 0; c < 20; c++) begin
            src_data = 8'($urandom);
            cycle();
        end
        chk("bp_ready", 32'(src_ready), 32'd0);
        chk("bp_data",  32'(cdc_data),  32'h3C);
        src_valid = 1'b0;
        frz       = 1'b0;
        n = 0;
        while (!src_ready && n < 10) begin
            cycle();
            n++;
        end
        chk("bp_release_lat", 32'(n), 32'(SD + 1));

        // Async reset while waiting for ack; make sure req is 1 while waiting
        if (cdc_req) begin
            src_valid = 1'b1;
            src_data  = 8'h11;
            cycle();
            src_valid = 1'b0;
            wait_ready();
        end
        src_valid = 1'b1;
        src_data  = 8'h5A;
        frz_val   = cdc_req;
        frz       = 1'b1;
        cycle();
        src_valid = 1'b0;
        cycle();
        #2 src_rst_n = 1'b0;
        #1;
        chk("ar_ready", 32'(src_ready), 32'd0);
        chk("ar_req",   32'(cdc_req),   32'd0);
        chk("ar_data",  32'(cdc_data),  32'd0);
        model_reset();
        frz = 1'b0;
        @(negedge src_clk);
        repeat (2) cycle();
        src_rst_n = 1'b1;
        m_init    = 1'b1;
        repeat (2) cycle();

        // Spurious ack toggle while idle
        frz_val = 1'b1;
        frz     = 1'b1;
        n = 0;
        while (!src_err && n < 10) begin
            cycle();
            n++;
        end
        chk("spur_lat", 32'(n), 32'(SD + 1));
        repeat (5) cycle();
        frz = 1'b0;
        repeat (5) cycle();
        chk("spur_sticky", 32'(src_err), 32'd1);
        src_rst_n = 1'b0;
        model_reset();
        #1 chk("spur_clear", 32'(src_err), 32'd0);
        cycle();
        src_rst_n = 1'b1;
        m_init    = 1'b1;
        repeat (2) cycle();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
